// File: rtl/q2_serial_acc.sv
// Bit-serial accumulator/operand stage for the q2 1-bit ALU slice: holds A, X, F and the op code,
// and runs one WIDTH-cycle serial operation per accepted start. Optional macro: Q2_SERIAL_ACC_LOAD_EN.
module q2_serial_acc #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x_in,
`ifdef Q2_SERIAL_ACC_LOAD_EN
    input  logic             acc_load,
    input  logic [WIDTH-1:0] acc_in,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic             flag_out,
    output logic             a0,
    output logic             x0,
    output logic             x1,
    output logic             f,
    output logic             op3,
    output logic             op4,
    input  logic             alu_out,
    input  logic             alu_cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             f_q, f_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    count_q, count_d;

    logic             load_req;
    logic [WIDTH-1:0] load_val;

`ifdef Q2_SERIAL_ACC_LOAD_EN
    assign load_req = acc_load;
    assign load_val = acc_in;
`else
    assign load_req = 1'b0;
    assign load_val = '0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        x_d     = x_q;
        f_d     = f_q;
        op_d    = op_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                // A direct load wins over a simultaneous start; that start is dropped.
                if (load_req) begin
                    a_d = load_val;
                end else if (start) begin
                    x_d     = x_in;
                    op_d    = op;
                    count_d = '0;
                    // Load and NOR seed F for zero detection; add and shift keep F as carry-in/fill.
                    if (!op[1]) begin
                        f_d = 1'b1;
                    end
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d = {alu_out, a_q[WIDTH-1:1]};
                x_d = {f_q, x_q[WIDTH-1:1]};
                f_d = alu_cout;
                if (count_q == LAST_COUNT) begin
                    count_d = '0;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            x_q     <= '0;
            f_q     <= 1'b0;
            op_q    <= 2'b00;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            f_q     <= f_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    // Everything visible to the ALU is a plain register decode.
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign acc_out  = a_q;
    assign flag_out = f_q;
    assign a0       = a_q[0];
    assign x0       = x_q[0];
    assign x1       = x_q[1];
    assign f        = f_q;
    assign op3      = op_q[0];
    assign op4      = op_q[1];

endmodule

// File: tb/tb_q2_serial_acc.sv
// Randomized bench for q2_serial_acc: a behavioural ALU slice closes the loop and
// results are compared with a word-level arithmetic model of each op.
module tb_q2_serial_acc;

    localparam int W = 12;
    localparam logic [W-1:0] MASK = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] x_in = '0;
`ifdef Q2_SERIAL_ACC_LOAD_EN
    logic         acc_load = 1'b0;
    logic [W-1:0] acc_in = '0;
`endif
    logic         busy, done, flag_out, a0, x0, x1, f, op3, op4;
    logic [W-1:0] acc_out;
    logic         alu_out, alu_cout;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] a_m = '0;
    logic         f_m = 1'b0;

    always #5 clk = ~clk;

    q2_serial_acc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op_i), .x_in(x_in),
`ifdef Q2_SERIAL_ACC_LOAD_EN
        .acc_load(acc_load), .acc_in(acc_in),
`endif
        .busy(busy), .done(done), .acc_out(acc_out), .flag_out(flag_out),
        .a0(a0), .x0(x0), .x1(x1), .f(f), .op3(op3), .op4(op4),
        .alu_out(alu_out), .alu_cout(alu_cout)
    );

    // 1-bit ALU slice: load/zero-detect, NOR/zero-detect, full add, shift through F.
    always_comb begin
        alu_out  = 1'b0;
        alu_cout = 1'b0;
        case ({op4, op3})
            2'b00: begin alu_out = x0;             alu_cout = f & ~x0; end
            2'b01: begin alu_out = ~(a0 | x0);     alu_cout = f & (a0 | x0); end
            2'b10: begin alu_out = a0 ^ x0 ^ f;    alu_cout = (a0 & x0) | (a0 & f) | (x0 & f); end
            default: begin alu_out = x1;           alu_cout = f; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input logic [1:0] o, input logic [W-1:0] x);
        logic [W:0]   s;
        logic [W-1:0] r;
        case (o)
            2'b00: begin a_m = x; f_m = (x == '0); end
            2'b01: begin r = ~(a_m | x) & MASK; a_m = r; f_m = (r == '0); end
            2'b10: begin
                s = {1'b0, a_m} + {1'b0, x} + (W+1)'(f_m);
                a_m = s[W-1:0];
                f_m = s[W];
            end
            default: a_m = {f_m, x[W-1:1]};
        endcase
    endtask

    // mode 0: plain op; 1: stray start in RUN and DONE; 2: reset in the middle of RUN
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input int mode);
        logic [W-1:0] a_before;
        @(negedge clk);
        start = 1'b1; op_i = o; x_in = x;
        @(posedge clk); #1;
        start = 1'b0; op_i = 2'($urandom); x_in = W'($urandom);
        check_eq("busy_after_accept", 32'(busy), 32'(1));
        check_eq("op_latched", 32'({op4, op3}), 32'(o));
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #1;
            if (mode == 1 && k == 6) start = 1'b0;
            if (mode == 2 && k == 6) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                a_m = '0; f_m = 1'b0;
                check_eq("rst_busy", 32'(busy), 32'(0));
                check_eq("rst_done", 32'(done), 32'(0));
                check_eq("rst_acc", 32'(acc_out), 32'(a_m));
                check_eq("rst_flag", 32'(flag_out), 32'(f_m));
                for (int j = 0; j < W + 2; j++) begin
                    @(posedge clk); #1;
                    check_eq("rst_no_done", 32'(done), 32'(0));
                end
                return;
            end
            if (mode == 1 && k == 5) begin
                start = 1'b1; op_i = 2'($urandom); x_in = W'($urandom);
            end
            if (k < W) begin
                check_eq("run_done_low", 32'(done), 32'(0));
                check_eq("run_busy", 32'(busy), 32'(1));
            end
        end
        model_apply(o, x);
        check_eq("done_pulse", 32'(done), 32'(1));
        check_eq("result_acc", 32'(acc_out), 32'(a_m));
        check_eq("result_flag", 32'(flag_out), 32'(f_m));
        if (mode == 1) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("done_one_cycle", 32'(done), 32'(0));
        check_eq("idle_busy", 32'(busy), 32'(0));
        a_before = acc_out;
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
            @(posedge clk); #1;
            check_eq("idle_stay", 32'(busy), 32'(0));
            check_eq("idle_stable_acc", 32'(acc_out), 32'(a_m));
        end
        check_eq("idle_acc_unchanged", 32'(acc_out), 32'(a_before));
    endtask

    initial begin
        int mode;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_acc", 32'(acc_out), 32'(0));
        check_eq("reset_flag", 32'(flag_out), 32'(0));
        check_eq("reset_busy", 32'(busy), 32'(0));
        check_eq("reset_done", 32'(done), 32'(0));
        check_eq("reset_op", 32'({op4, op3}), 32'(0));

        // Directed cases with hand-derived results
        do_op(2'b00, 12'hABC, 0);
        check_eq("load_abc", 32'(acc_out), 32'h0ABC);
        check_eq("load_abc_f", 32'(flag_out), 32'(0));
        do_op(2'b00, 12'h000, 0);
        check_eq("load_zero_f", 32'(flag_out), 32'(1));
        do_op(2'b00, 12'h0FF, 0);
        do_op(2'b10, 12'h001, 0);
        check_eq("add_100", 32'(acc_out), 32'h0100);
        check_eq("add_100_f", 32'(flag_out), 32'(0));
        do_op(2'b00, 12'h000, 0);
        do_op(2'b00, 12'hFFF, 0);
        do_op(2'b10, 12'h001, 0);
        check_eq("add_wrap", 32'(acc_out), 32'h0000);
        check_eq("add_wrap_f", 32'(flag_out), 32'(1));
        do_op(2'b11, 12'h801, 0);
        check_eq("shift_c00", 32'(acc_out), 32'h0C00);
        check_eq("shift_f", 32'(flag_out), 32'(1));
        do_op(2'b00, 12'h0F0, 0);
        do_op(2'b01, 12'h00F, 0);
        check_eq("nor_f00", 32'(acc_out), 32'h0F00);
        check_eq("nor_f00_f", 32'(flag_out), 32'(0));
        do_op(2'b00, 12'hFFF, 0);
        do_op(2'b01, 12'h000, 0);
        check_eq("nor_zero", 32'(acc_out), 32'h0000);
        check_eq("nor_zero_f", 32'(flag_out), 32'(1));
        do_op(2'b00, 12'h123, 1);
        check_eq("stray_start_acc", 32'(acc_out), 32'h0123);
        do_op(2'b10, 12'h456, 2);
        check_eq("abort_acc", 32'(acc_out), 32'(0));

`ifdef Q2_SERIAL_ACC_LOAD_EN
        @(negedge clk);
        acc_load = 1'b1; acc_in = 12'h5A5; start = 1'b1; op_i = 2'b10; x_in = 12'h111;
        @(posedge clk); #1;
        acc_load = 1'b0; start = 1'b0;
        a_m = 12'h5A5;
        check_eq("load_en_acc", 32'(acc_out), 32'(a_m));
        check_eq("load_en_busy", 32'(busy), 32'(0));
        check_eq("load_en_flag", 32'(flag_out), 32'(f_m));
        @(posedge clk); #1;
        check_eq("load_en_no_run", 32'(busy), 32'(0));
`endif

        // Randomized sequence of ops with occasional stray starts and aborts
        for (int i = 0; i < 40; i++) begin
            mode = ($urandom_range(0, 9) == 0) ? 2 : (($urandom_range(0, 4) == 0) ? 1 : 0);
            do_op(2'($urandom), W'($urandom), mode);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
